// File: rtl/btr_pkg.sv
// Shared mode encodings for the btr bit-permutation unit.
// Imported by btr_perm and btr_pipe.
package btr_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_REV    = 2'd0;
  localparam mode_t MODE_BSWAP  = 2'd1;
  localparam mode_t MODE_GRPREV = 2'd2;
  localparam mode_t MODE_PASS   = 2'd3;

endpackage

// File: rtl/btr_perm.sv
// Combinational bit permutation: full reverse, byte swap, per-group reverse, pass.
// Ports: i_data/i_mode in, o_data out (pure wiring plus a 4:1 mux).
module btr_perm
  import btr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic [WIDTH-1:0] i_data,
  input  mode_t            i_mode,
  output logic [WIDTH-1:0] o_data
);

  localparam int NB = WIDTH / 8;
  localparam int NG = WIDTH / GROUP;

  logic [WIDTH-1:0] w_rev;
  logic [WIDTH-1:0] w_bswap;
  logic [WIDTH-1:0] w_grp;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign w_rev[i] = i_data[WIDTH-1-i];
  end

  for (genvar k = 0; k < NB; k++) begin : g_bswap
    assign w_bswap[8*k +: 8] = i_data[8*(NB-1-k) +: 8];
  end

  for (genvar g = 0; g < NG; g++) begin : g_grp
    for (genvar b = 0; b < GROUP; b++) begin : g_bit
      assign w_grp[g*GROUP+b] = i_data[g*GROUP+GROUP-1-b];
    end
  end

  always_comb begin
    o_data = i_data;
    unique case (1'b1)
      (i_mode == MODE_REV):    o_data = w_rev;
      (i_mode == MODE_BSWAP):  o_data = w_bswap;
      (i_mode == MODE_GRPREV): o_data = w_grp;
      default:                 o_data = i_data;
    endcase
  end

endmodule

// File: rtl/btr_pipe.sv
// Two-stage valid/ready bit-permutation pipe (S1 = {In,Mode}, S2 = Out).
// Ports: clk, rst_n, In, Mode, in_valid/in_ready, Out, out_valid/out_ready,
// out_parity (only when BTR_PARITY_EN is defined).
module btr_pipe
  import btr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] In,
  input  mode_t            Mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef BTR_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  if ((WIDTH % 8) != 0) begin : g_bad_width
    $error("btr_pipe: WIDTH must be a multiple of 8");
  end
  if ((GROUP <= 0) || ((WIDTH % GROUP) != 0)) begin : g_bad_group
    $error("btr_pipe: GROUP must divide WIDTH");
  end

  logic [WIDTH-1:0] r_s1_data;
  mode_t            r_s1_mode;
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic [WIDTH-1:0] w_perm;
  logic             w_s2_adv;
  logic             w_accept;

  // S1 moves on whenever S2 is empty or being drained this cycle.
  assign w_s2_adv = r_s1_valid & (~r_out_valid | out_ready);
  assign in_ready = ~r_s1_valid | w_s2_adv;
  assign w_accept = in_valid & in_ready;

  btr_perm #(
    .WIDTH (WIDTH),
    .GROUP (GROUP)
  ) u_perm (
    .i_data (r_s1_data),
    .i_mode (r_s1_mode),
    .o_data (w_perm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_data  <= '0;
      r_s1_mode  <= MODE_REV;
      r_s1_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_data <= In;
        r_s1_mode <= Mode;
      end
      r_s1_valid <= w_accept | (r_s1_valid & ~w_s2_adv);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_s2_adv) begin
      r_out       <= w_perm;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign Out       = r_out;
  assign out_valid = r_out_valid;

`ifdef BTR_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (w_s2_adv) begin
      r_par <= ^w_perm;
    end
  end

  assign out_parity = r_par;
`endif

endmodule

// File: tb/tb_btr_pipe.sv
// Directed self-checking bench for btr_pipe (16/4 instance plus a 32/8 instance).
// Inputs driven 1ns after the rising edge, outputs sampled 1ns later.
module tb_btr_pipe;
  import btr_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  mode_t       dmode;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dout;
  logic        out_valid;
  logic        out_ready;
`ifdef BTR_PARITY_EN
  logic        out_parity;
`endif

  logic [31:0] wi_data;
  mode_t       wi_mode;
  logic        wi_valid;
  logic        wi_ready;
  logic [31:0] wo_data;
  logic        wo_valid;
`ifdef BTR_PARITY_EN
  logic        wo_parity;
`endif

  int n_cmp;
  int n_err;

  btr_pipe #(.WIDTH(16), .GROUP(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .In        (din),
    .Mode      (dmode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Out       (dout),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef BTR_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  btr_pipe #(.WIDTH(32), .GROUP(8)) u_wide (
    .clk       (clk),
    .rst_n     (rst_n),
    .In        (wi_data),
    .Mode      (wi_mode),
    .in_valid  (wi_valid),
    .in_ready  (wi_ready),
    .Out       (wo_data),
    .out_valid (wo_valid),
    .out_ready (1'b1)
`ifdef BTR_PARITY_EN
    ,
    .out_parity(wo_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_out_valid got=%b want=0", out_valid);
    end
    n_cmp++;
    if (dout !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_out got=%h want=0000", dout);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_in_ready got=%b want=1", in_ready);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_rst got rdy=%b ov=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_modes();
    logic [15:0] vin [5];
    logic [15:0] vexp[5];
    mode_t       vm  [5];
    vin[0] = 16'h0001; vm[0] = MODE_REV;    vexp[0] = 16'h8000;
    vin[1] = 16'h1234; vm[1] = MODE_BSWAP;  vexp[1] = 16'h3412;
    vin[2] = 16'h1234; vm[2] = MODE_GRPREV; vexp[2] = 16'h84C2;
    vin[3] = 16'hBEEF; vm[3] = MODE_PASS;   vexp[3] = 16'hBEEF;
    vin[4] = 16'h1234; vm[4] = MODE_REV;    vexp[4] = 16'h2C48;
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      din = vin[v];
      dmode = vm[v];
      in_valid = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL mode%0d_in_ready got=%b want=1", v, in_ready);
      end
      step();
      in_valid = 1'b0;
      din = 16'h0000;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL mode%0d_early got ov=%b want=0", v, out_valid);
      end
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || dout !== vexp[v]) begin
        n_err++;
        $display("FAIL mode%0d_result got ov=%b out=%h want 1/%h",
                 v, out_valid, dout, vexp[v]);
      end
      step();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL mode%0d_drain got ov=%b want=0", v, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bin [8];
    logic [15:0] bexp[8];
    mode_t       bm  [8];
    bin[0] = 16'h0001; bm[0] = MODE_REV;    bexp[0] = 16'h8000;
    bin[1] = 16'h00FF; bm[1] = MODE_BSWAP;  bexp[1] = 16'hFF00;
    bin[2] = 16'h1111; bm[2] = MODE_GRPREV; bexp[2] = 16'h8888;
    bin[3] = 16'h1234; bm[3] = MODE_PASS;   bexp[3] = 16'h1234;
    bin[4] = 16'h8000; bm[4] = MODE_REV;    bexp[4] = 16'h0001;
    bin[5] = 16'hABCD; bm[5] = MODE_BSWAP;  bexp[5] = 16'hCDAB;
    bin[6] = 16'h0F0F; bm[6] = MODE_GRPREV; bexp[6] = 16'h0F0F;
    bin[7] = 16'hBEEF; bm[7] = MODE_PASS;   bexp[7] = 16'hBEEF;
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c < 8) begin
        din = bin[c];
        dmode = bm[c];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_in_ready c=%0d got=%b want=1", c, in_ready);
      end
      step();
      if (c >= 1) begin
        n_cmp++;
        if (out_valid !== 1'b1 || dout !== bexp[c-1]) begin
          n_err++;
          $display("FAIL b2b_out%0d got ov=%b out=%h want 1/%h",
                   c - 1, out_valid, dout, bexp[c-1]);
        end
      end
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain got ov=%b want=0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] pin [5];
    logic [15:0] pexp[5];
    mode_t       pm  [5];
    int          idx;
    int          pops;
    logic        want_rdy;
    pin[0] = 16'h0003; pm[0] = MODE_REV;    pexp[0] = 16'hC000;
    pin[1] = 16'h1200; pm[1] = MODE_BSWAP;  pexp[1] = 16'h0012;
    pin[2] = 16'h8421; pm[2] = MODE_GRPREV; pexp[2] = 16'h1248;
    pin[3] = 16'h5A5A; pm[3] = MODE_PASS;   pexp[3] = 16'h5A5A;
    pin[4] = 16'hFFFE; pm[4] = MODE_REV;    pexp[4] = 16'h7FFF;
    idx = 0;
    pops = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
      in_valid = (idx < 5);
      if (idx < 5) begin
        din = pin[idx];
        dmode = pm[idx];
      end
      #1;
      want_rdy = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
      n_cmp++;
      if (in_ready !== want_rdy) begin
        n_err++;
        $display("FAIL bp_in_ready c=%0d got=%b want=%b", c, in_ready, want_rdy);
      end
      if (c >= 2 && c <= 6) begin
        n_cmp++;
        if (out_valid !== 1'b1 || dout !== 16'hC000) begin
          n_err++;
          $display("FAIL bp_stall c=%0d got ov=%b out=%h want 1/c000",
                   c, out_valid, dout);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (pops < 5) begin
          n_cmp++;
          if (dout !== pexp[pops]) begin
            n_err++;
            $display("FAIL bp_pop%0d got=%h want=%h", pops, dout, pexp[pops]);
          end
        end
        pops++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) idx++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (pops != 5) begin
      n_err++;
      $display("FAIL bp_pop_count got=%0d want=5", pops);
    end
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b0;
    din = 16'h0001;
    dmode = MODE_PASS;
    in_valid = 1'b1;
    step();
    din = 16'h0002;
    step();
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rif_full got ov=%b rdy=%b want 1/0", out_valid, in_ready);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || dout !== 16'h0000) begin
      n_err++;
      $display("FAIL rif_async got ov=%b out=%h want 0/0000", out_valid, dout);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rif_in_ready got=%b want=1", in_ready);
    end
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rif_discard got ov=%b want=0", out_valid);
    end
    din = 16'h1357;
    dmode = MODE_PASS;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rif_lat1 got ov=%b want=0", out_valid);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || dout !== 16'h1357) begin
      n_err++;
      $display("FAIL rif_lat2 got ov=%b out=%h want 1/1357", out_valid, dout);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rif_drain got ov=%b want=0", out_valid);
    end
  endtask

`ifdef BTR_PARITY_EN
  task automatic test_parity();
    logic [15:0] pin[2];
    logic        pexp[2];
    pin[0] = 16'h0007; pexp[0] = 1'b1;
    pin[1] = 16'h0003; pexp[1] = 1'b0;
    out_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      din = pin[v];
      dmode = MODE_PASS;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_parity !== pexp[v]) begin
        n_err++;
        $display("FAIL parity%0d got ov=%b par=%b want 1/%b",
                 v, out_valid, out_parity, pexp[v]);
      end
      step();
    end
  endtask
`endif

  task automatic test_wide();
    logic [31:0] win [3];
    logic [31:0] wexp[3];
    mode_t       wm  [3];
    win[0] = 32'h11223344; wm[0] = MODE_BSWAP;  wexp[0] = 32'h44332211;
    win[1] = 32'h01800000; wm[1] = MODE_GRPREV; wexp[1] = 32'h80010000;
    win[2] = 32'h00000001; wm[2] = MODE_REV;    wexp[2] = 32'h80000000;
    for (int v = 0; v < 3; v++) begin
      wi_data = win[v];
      wi_mode = wm[v];
      wi_valid = 1'b1;
      #1;
      n_cmp++;
      if (wi_ready !== 1'b1) begin
        n_err++;
        $display("FAIL wide%0d_in_ready got=%b want=1", v, wi_ready);
      end
      step();
      wi_valid = 1'b0;
      step();
      n_cmp++;
      if (wo_valid !== 1'b1 || wo_data !== wexp[v]) begin
        n_err++;
        $display("FAIL wide%0d got ov=%b out=%h want 1/%h",
                 v, wo_valid, wo_data, wexp[v]);
      end
      step();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    din = 16'h0000;
    dmode = MODE_REV;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wi_data = 32'h0;
    wi_mode = MODE_REV;
    wi_valid = 1'b0;
    #1;
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
`ifdef BTR_PARITY_EN
    test_parity();
`endif
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
